// File: rtl/game_sequencer_pkg.sv
// Shared state encodings for the shooter game-flow controller.
package game_sequencer_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StAttract = 3'd0,
    StPlay    = 3'd1,
    StPaused  = 3'd2,
    StHit     = 3'd3,
    StOver    = 3'd4
  } state_e;

endpackage

// File: rtl/game_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, 1-CLK pulse on debounced press.
module game_sequencer_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic CLK,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q;

  // Level only flips after DEBOUNCE_CYC consecutive samples disagreeing with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: ATTRACT/PLAY/PAUSED/HIT/OVER FSM with lives, score and invulnerability.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter int unsigned LIVES         = 3,
  parameter int unsigned HIT_FRAMES    = 60,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned BONUS         = 10,
  parameter int unsigned SCORE_W       = 16
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic               i_pause_btn,
  input  logic               i_start_btn,
  input  logic               i_collide,
  input  logic               i_target_hit,
  output logic               o_run,
  output logic               o_sprite_rst,
  output logic               o_flash,
  output logic [StateW-1:0]  o_state,
  output logic [2:0]         o_lives,
  output logic [SCORE_W-1:0] o_score
);

  // At least 4 bits so invuln_q[3] always exists for the blink.
  localparam int unsigned InvW = ($clog2(INVULN_FRAMES + 1) > 4) ? $clog2(INVULN_FRAMES + 1) : 4;
  localparam int unsigned HitW = ($clog2(HIT_FRAMES + 1) > 1) ? $clog2(HIT_FRAMES + 1) : 1;

  state_e             state_q, state_d;
  logic [2:0]         lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [InvW-1:0]    invuln_q, invuln_d;
  logic [HitW-1:0]    hit_cnt_q, hit_cnt_d;
  logic               coll_seen_q, coll_seen_d;
  logic               sprite_rst_q, sprite_rst_d;

  logic             start_press, pause_press;
  logic             coll_set, coll_hit;
  logic [SCORE_W:0] score_inc, score_sum;

  game_sequencer_btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_start_db (
    .CLK    (CLK),
    .rst    (rst),
    .btn_i  (i_start_btn),
    .press_o(start_press)
  );

  game_sequencer_btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_pause_db (
    .CLK    (CLK),
    .rst    (rst),
    .btn_i  (i_pause_btn),
    .press_o(pause_press)
  );

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    score_d      = score_q;
    invuln_d     = invuln_q;
    hit_cnt_d    = hit_cnt_q;
    sprite_rst_d = 1'b0;

    coll_set    = i_collide & i_pix_stb & (state_q == StPlay) & (invuln_q == '0);
    coll_hit    = coll_seen_q | coll_set;
    coll_seen_d = i_animate ? 1'b0 : coll_hit;

    score_inc = '0;
    if (i_animate)    score_inc = score_inc + 1'b1;
    if (i_target_hit) score_inc = score_inc + (SCORE_W + 1)'(BONUS);
    score_sum = {1'b0, score_q} + score_inc;

    case (state_q)
      StAttract: begin
        if (start_press) begin
          state_d   = StPlay;
          lives_d   = 3'(LIVES);
          score_d   = '0;
          invuln_d  = '0;
          hit_cnt_d = '0;
        end
      end
      StPlay: begin
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (i_animate && (invuln_q != '0)) invuln_d = invuln_q - 1'b1;
        // A collision on this frame outranks a simultaneous pause press.
        if (i_animate && coll_hit) begin
          hit_cnt_d = '0;
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            state_d = StHit;
          end else begin
            lives_d = '0;
            state_d = StOver;
          end
        end else if (pause_press) begin
          state_d = StPaused;
        end
      end
      StPaused: begin
        if (pause_press) state_d = StPlay;
      end
      StHit: begin
        if (i_animate) begin
          if (hit_cnt_q == HitW'(HIT_FRAMES - 1)) begin
            hit_cnt_d = '0;
            invuln_d  = InvW'(INVULN_FRAMES);
            state_d   = StPlay;
          end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end
      end
      StOver: begin
        lives_d = '0;
        if (start_press) begin
          state_d      = StPlay;
          lives_d      = 3'(LIVES);
          score_d      = '0;
          invuln_d     = '0;
          hit_cnt_d    = '0;
          sprite_rst_d = 1'b1;
        end
      end
      default: state_d = StAttract;
    endcase

    if (state_d == StAttract) sprite_rst_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= StAttract;
      lives_q      <= 3'(LIVES);
      score_q      <= '0;
      invuln_q     <= '0;
      hit_cnt_q    <= '0;
      coll_seen_q  <= 1'b0;
      sprite_rst_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      invuln_q     <= invuln_d;
      hit_cnt_q    <= hit_cnt_d;
      coll_seen_q  <= coll_seen_d;
      sprite_rst_q <= sprite_rst_d;
    end
  end

  assign o_run        = (state_q == StPlay);
  assign o_sprite_rst = sprite_rst_q;
  assign o_flash      = (state_q == StPlay) & (invuln_q != '0) & invuln_q[3];
  assign o_state      = state_q;
  assign o_lives      = lives_q;
  assign o_score      = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with short debounce and frame counts.
module tb_game_sequencer;

  logic        CLK, rst;
  logic        i_pix_stb, i_animate, i_pause_btn, i_start_btn, i_collide, i_target_hit;
  logic        o_run, o_sprite_rst, o_flash;
  logic [2:0]  o_state, o_lives;
  logic [15:0] o_score;

  int n_checks = 0;
  int n_errors = 0;
  int exp_score, exp_inv, rst_cnt;

  game_sequencer #(
    .DEBOUNCE_CYC (4),
    .LIVES        (2),
    .HIT_FRAMES   (2),
    .INVULN_FRAMES(16),
    .BONUS        (10),
    .SCORE_W      (16)
  ) dut (
    .CLK         (CLK),
    .rst         (rst),
    .i_pix_stb   (i_pix_stb),
    .i_animate   (i_animate),
    .i_pause_btn (i_pause_btn),
    .i_start_btn (i_start_btn),
    .i_collide   (i_collide),
    .i_target_hit(i_target_hit),
    .o_run       (o_run),
    .o_sprite_rst(o_sprite_rst),
    .o_flash     (o_flash),
    .o_state     (o_state),
    .o_lives     (o_lives),
    .o_score     (o_score)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic animate(input logic hit);
    i_animate    = 1'b1;
    i_target_hit = hit;
    cyc(1);
    i_animate    = 1'b0;
    i_target_hit = 1'b0;
  endtask

  task automatic collide();
    i_collide = 1'b1;
    i_pix_stb = 1'b1;
    cyc(1);
    i_collide = 1'b0;
    i_pix_stb = 1'b0;
  endtask

  task automatic press_pause();
    i_pause_btn = 1'b1;
    cyc(10);
    i_pause_btn = 1'b0;
    cyc(8);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(o_state), 0);
    check({tag, "_run"}, 32'(o_run), 0);
    check({tag, "_sprite_rst"}, 32'(o_sprite_rst), 1);
    check({tag, "_flash"}, 32'(o_flash), 0);
    check({tag, "_lives"}, 32'(o_lives), 2);
    check({tag, "_score"}, 32'(o_score), 0);
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  initial begin
    rst = 1'b1;
    {i_pix_stb, i_animate, i_pause_btn, i_start_btn, i_collide, i_target_hit} = '0;
    cyc(3);
    check_reset("reset");
    rst = 1'b0;
    cyc(2);
    check("attract_idle", 32'(o_state), 0);

    // 1. Start held long: one press, game begins.
    i_start_btn = 1'b1;
    cyc(20);
    i_start_btn = 1'b0;
    cyc(8);
    check("start_state", 32'(o_state), 1);
    check("start_run", 32'(o_run), 1);
    check("start_lives", 32'(o_lives), 2);
    check("start_score", 32'(o_score), 0);
    check("start_sprite_rst", 32'(o_sprite_rst), 0);
    repeat (3) animate(1'b0);
    exp_score = 3;
    check("score_3", 32'(o_score), 32'(exp_score));

    // 2. Bouncing pause is rejected; a clean hold pauses.
    for (int i = 0; i < 15; i++) begin
      i_pause_btn = ~i_pause_btn;
      cyc(2);
    end
    i_pause_btn = 1'b0;
    cyc(8);
    check("bounce_state", 32'(o_state), 1);
    press_pause();
    check("paused_state", 32'(o_state), 2);
    check("paused_run", 32'(o_run), 0);
    animate(1'b0);
    animate(1'b0);
    animate(1'b1);
    check("paused_score", 32'(o_score), 32'(exp_score));
    check("paused_hold", 32'(o_state), 2);
    press_pause();
    check("unpause_state", 32'(o_state), 1);

    // 3. Collision -> HIT -> PLAY with invulnerability blink.
    collide();
    animate(1'b0);
    exp_score++;
    check("hit_lives", 32'(o_lives), 1);
    check("hit_state", 32'(o_state), 3);
    check("hit_run", 32'(o_run), 0);
    animate(1'b0);
    check("hit_hold", 32'(o_state), 3);
    animate(1'b0);
    exp_inv = 16;
    check("hit_done", 32'(o_state), 1);
    check("hit_score", 32'(o_score), 32'(exp_score));
    check("flash_16", 32'(o_flash), 0);
    for (int k = 0; k < 16; k++) begin
      collide();
      animate(1'b0);
      exp_inv--;
      exp_score++;
      check("invuln_flash", 32'(o_flash), 32'((exp_inv != 0) && ((exp_inv & 8) != 0)));
      check("invuln_state", 32'(o_state), 1);
    end
    check("invuln_lives", 32'(o_lives), 1);
    check("invuln_score", 32'(o_score), 32'(exp_score));

    // 4. Last life lost -> OVER; restart pulses sprite reset once.
    collide();
    animate(1'b0);
    exp_score++;
    check("over_state", 32'(o_state), 4);
    check("over_lives", 32'(o_lives), 0);
    check("over_score", 32'(o_score), 32'(exp_score));
    rst_cnt = 0;
    i_start_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (o_sprite_rst) rst_cnt++;
    end
    i_start_btn = 1'b0;
    cyc(8);
    check("restart_rst_pulse", 32'(rst_cnt), 1);
    check("restart_state", 32'(o_state), 1);
    check("restart_lives", 32'(o_lives), 2);
    check("restart_score", 32'(o_score), 0);

    // 5. Coincident bonus and saturation.
    animate(1'b1);
    exp_score = 11;
    check("bonus_11", 32'(o_score), 32'(exp_score));
    i_target_hit = 1'b1;
    cyc(6552);
    i_target_hit = 1'b0;
    exp_score = sat16(exp_score + 10 * 6552);
    check("near_max", 32'(o_score), 32'(exp_score));
    animate(1'b0);
    exp_score = sat16(exp_score + 1);
    check("near_max_p1", 32'(o_score), 32'(exp_score));
    i_target_hit = 1'b1;
    cyc(1);
    i_target_hit = 1'b0;
    exp_score = sat16(exp_score + 10);
    check("saturate", 32'(o_score), 32'(exp_score));
    animate(1'b1);
    check("saturate_hold", 32'(o_score), 65535);

    // 6. Pause press lands on the collision frame: collision wins.
    collide();
    i_pause_btn = 1'b1;
    cyc(6);
    i_animate = 1'b1;
    cyc(1);
    i_animate = 1'b0;
    check("prio_state", 32'(o_state), 3);
    check("prio_lives", 32'(o_lives), 1);
    cyc(6);
    i_pause_btn = 1'b0;
    cyc(8);
    check("prio_hold", 32'(o_state), 3);
    rst = 1'b1;
    cyc(1);
    check_reset("mid_hit_rst");
    rst = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
